// File: rtl/inv_test_sequencer.sv
// Applies a programmed bit sequence to the analog inverter and measures each response
// delay in clk cycles, reporting timeouts, error count and worst-case delay.
module inv_test_sequencer #(
    parameter int NUM_VECTORS   = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] pattern,
    input  logic       resp_in,
    output logic       stim_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] max_delay,
    output logic       timeout_flag
);

    typedef enum logic [1:0] {IDLE, WAIT, SETTLE, DONE} state_t;

    state_t      state, state_nxt;
    logic        s1, s2;
    logic [7:0]  pat_q;
    logic [7:0]  idx;
    logic [7:0]  idx_inc;
    logic [7:0]  dcnt;
    logic [15:0] scnt;
    logic        resp_match;
    logic        wait_expired;
    logic        settle_end;
    logic        last_vec;

    assign resp_match   = (s2 == ~stim_out);
    assign wait_expired = (dcnt == 8'(TIMEOUT - 1));
    assign settle_end   = (scnt == 16'(SETTLE_CYCLES - 1));
    assign last_vec     = (idx == 8'(NUM_VECTORS - 1));
    assign idx_inc      = idx + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    if (resp_match || wait_expired) state_nxt = SETTLE;
            SETTLE:  if (settle_end) state_nxt = last_vec ? DONE : WAIT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            pat_q        <= '0;
            idx          <= '0;
            dcnt         <= '0;
            scnt         <= '0;
            stim_out     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            max_delay    <= '0;
            timeout_flag <= 1'b0;
        end else begin
            s1 <= resp_in;
            s2 <= s1;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_q        <= pattern;
                        err_count    <= '0;
                        max_delay    <= '0;
                        timeout_flag <= 1'b0;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                        idx          <= '0;
                        dcnt         <= '0;
                        busy         <= 1'b1;
                        stim_out     <= pattern[0];
                    end
                end
                WAIT: begin
                    // A match in the same cycle as expiry counts as resolved.
                    if (resp_match) begin
                        if (dcnt > max_delay) max_delay <= dcnt;
                        scnt <= '0;
                    end else if (wait_expired) begin
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        timeout_flag <= 1'b1;
                        scnt         <= '0;
                    end else begin
                        dcnt <= dcnt + 8'd1;
                    end
                end
                SETTLE: begin
                    if (settle_end) begin
                        if (!last_vec) begin
                            idx      <= idx_inc;
                            stim_out <= pat_q[idx_inc[2:0]];
                            dcnt     <= '0;
                        end
                    end else begin
                        scnt <= scnt + 16'd1;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == 8'd0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_test_sequencer.sv
// Directed bench for inv_test_sequencer with an inverter model (ideal, 3-cycle delay, stuck-at-0).
module tb_inv_test_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic       resp_in;
    logic       stim_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] max_delay;
    logic       timeout_flag;

    int         tests = 0;
    int         fails = 0;
    int         mode  = 0;   // 0 ideal, 1 three-cycle delay, 2 stuck at 0
    logic [2:0] hist  = 3'b000;

    inv_test_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pattern      (pattern),
        .resp_in      (resp_in),
        .stim_out     (stim_out),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .max_delay    (max_delay),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) hist <= {hist[1:0], stim_out};

    always_comb begin
        case (mode)
            1:       resp_in = ~hist[2];
            2:       resp_in = 1'b0;
            default: resp_in = ~stim_out;
        endcase
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [7:0] p);
        start   = 1'b1;
        pattern = p;
        tick(1);
        start   = 1'b0;
    endtask

    // Counts cycles from the accepted start edge until done is seen; -1 on timeout.
    task automatic wait_done(input int restart_at, output int n, output bit busy_ok);
        n       = 0;
        busy_ok = 1'b1;
        while (1'b1) begin
            tick(1);
            n++;
            start = 1'b0;
            if (restart_at != 0 && n == restart_at) begin
                start   = 1'b1;
                pattern = 8'hFF;
            end
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (n >= 5000) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic quiet_reset();
        rst  = 1'b1;
        mode = 0;
        tick(1);
        rst  = 1'b0;
        tick(5);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        tests += 7;
        if (stim_out !== 1'b0)      begin fails++; $display("FAIL reset_stim: got %b want 0", stim_out); end
        if (busy !== 1'b0)          begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)          begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        if (pass !== 1'b0)          begin fails++; $display("FAIL reset_pass: got %b want 0", pass); end
        if (err_count !== 8'd0)     begin fails++; $display("FAIL reset_err: got %0d want 0", err_count); end
        if (max_delay !== 8'd0)     begin fails++; $display("FAIL reset_maxd: got %0d want 0", max_delay); end
        if (timeout_flag !== 1'b0)  begin fails++; $display("FAIL reset_tflag: got %b want 0", timeout_flag); end
        rst = 1'b0;
        tick(5);
    endtask

    task automatic test_ideal();
        int n;
        bit bok;
        mode = 0;
        pulse_start(8'h55);
        tests += 2;
        if (stim_out !== 1'b1) begin fails++; $display("FAIL ideal_first_stim: got %b want 1", stim_out); end
        if (busy !== 1'b1)     begin fails++; $display("FAIL ideal_busy_start: got %b want 1", busy); end
        wait_done(0, n, bok);
        tests += 7;
        if (n != 113)              begin fails++; $display("FAIL ideal_cycles: got %0d want 113", n); end
        if (bok !== 1'b1)          begin fails++; $display("FAIL ideal_busy_run: busy dropped before done"); end
        if (busy !== 1'b0)         begin fails++; $display("FAIL ideal_busy_end: got %b want 0", busy); end
        if (pass !== 1'b1)         begin fails++; $display("FAIL ideal_pass: got %b want 1", pass); end
        if (err_count !== 8'd0)    begin fails++; $display("FAIL ideal_err: got %0d want 0", err_count); end
        if (max_delay !== 8'd2)    begin fails++; $display("FAIL ideal_maxd: got %0d want 2", max_delay); end
        if (timeout_flag !== 1'b0) begin fails++; $display("FAIL ideal_tflag: got %b want 0", timeout_flag); end
        tick(3);
        tests += 1;
        if (done !== 1'b1) begin fails++; $display("FAIL ideal_done_held: got %b want 1", done); end
    endtask

    task automatic test_delay3();
        int n;
        bit bok;
        mode = 1;
        pulse_start(8'hA5);
        wait_done(0, n, bok);
        tests += 4;
        if (done !== 1'b1)      begin fails++; $display("FAIL delay_done: got %b want 1 (n=%0d)", done, n); end
        if (max_delay !== 8'd5) begin fails++; $display("FAIL delay_maxd: got %0d want 5", max_delay); end
        if (err_count !== 8'd0) begin fails++; $display("FAIL delay_err: got %0d want 0", err_count); end
        if (pass !== 1'b1)      begin fails++; $display("FAIL delay_pass: got %b want 1", pass); end
    endtask

    task automatic test_stuck0();
        int n;
        int low;
        bit bok;
        quiet_reset();
        pulse_start(8'h55);
        mode = 2;
        n = 0;
        while (stim_out !== 1'b0 && n < 1000) begin tick(1); n++; end
        low = 0;
        while (stim_out !== 1'b1 && low < 1000) begin tick(1); low++; end
        tests += 1;
        if (low != 204) begin fails++; $display("FAIL stuck_wait_len: got %0d want 204", low); end
        wait_done(0, n, bok);
        tests += 5;
        if (done !== 1'b1)         begin fails++; $display("FAIL stuck_done: got %b want 1", done); end
        if (err_count !== 8'd8)    begin fails++; $display("FAIL stuck_err: got %0d want 8", err_count); end
        if (timeout_flag !== 1'b1) begin fails++; $display("FAIL stuck_tflag: got %b want 1", timeout_flag); end
        if (pass !== 1'b0)         begin fails++; $display("FAIL stuck_pass: got %b want 0", pass); end
        if (max_delay !== 8'd2)    begin fails++; $display("FAIL stuck_maxd: got %0d want 2", max_delay); end
    endtask

    task automatic test_restart_ignored();
        int n;
        bit bok;
        quiet_reset();
        pulse_start(8'h55);
        wait_done(10, n, bok);
        tests += 4;
        if (n != 113)           begin fails++; $display("FAIL restart_cycles: got %0d want 113", n); end
        if (pass !== 1'b1)      begin fails++; $display("FAIL restart_pass: got %b want 1", pass); end
        if (max_delay !== 8'd2) begin fails++; $display("FAIL restart_maxd: got %0d want 2", max_delay); end
        if (err_count !== 8'd0) begin fails++; $display("FAIL restart_err: got %0d want 0", err_count); end
    endtask

    task automatic test_mid_reset();
        int n;
        bit bok;
        quiet_reset();
        pulse_start(8'h55);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tests += 4;
        if (stim_out !== 1'b0)  begin fails++; $display("FAIL midrst_stim: got %b want 0", stim_out); end
        if (busy !== 1'b0)      begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (done !== 1'b0)      begin fails++; $display("FAIL midrst_done: got %b want 0", done); end
        if (max_delay !== 8'd0) begin fails++; $display("FAIL midrst_maxd: got %0d want 0", max_delay); end
        tick(5);
        pulse_start(8'hAA);
        wait_done(0, n, bok);
        tests += 4;
        if (n != 111)           begin fails++; $display("FAIL midrst_cycles: got %0d want 111", n); end
        if (pass !== 1'b1)      begin fails++; $display("FAIL midrst_pass: got %b want 1", pass); end
        if (max_delay !== 8'd2) begin fails++; $display("FAIL midrst_maxd_run: got %0d want 2", max_delay); end
        if (err_count !== 8'd0) begin fails++; $display("FAIL midrst_err: got %0d want 0", err_count); end
    endtask

    task automatic test_back_to_back();
        int n;
        bit bok;
        pulse_start(8'h00);
        wait_done(0, n, bok);
        tests += 3;
        if (n != 83)            begin fails++; $display("FAIL b2b_run1_cycles: got %0d want 83", n); end
        if (max_delay !== 8'd2) begin fails++; $display("FAIL b2b_run1_maxd: got %0d want 2", max_delay); end
        if (pass !== 1'b1)      begin fails++; $display("FAIL b2b_run1_pass: got %b want 1", pass); end
        pulse_start(8'hFF);
        tests += 4;
        if (done !== 1'b0)      begin fails++; $display("FAIL b2b_clear_done: got %b want 0", done); end
        if (pass !== 1'b0)      begin fails++; $display("FAIL b2b_clear_pass: got %b want 0", pass); end
        if (max_delay !== 8'd0) begin fails++; $display("FAIL b2b_clear_maxd: got %0d want 0", max_delay); end
        if (busy !== 1'b1)      begin fails++; $display("FAIL b2b_busy: got %b want 1", busy); end
        wait_done(0, n, bok);
        tests += 3;
        if (n != 83)            begin fails++; $display("FAIL b2b_run2_cycles: got %0d want 83", n); end
        if (max_delay !== 8'd2) begin fails++; $display("FAIL b2b_run2_maxd: got %0d want 2", max_delay); end
        if (pass !== 1'b1)      begin fails++; $display("FAIL b2b_run2_pass: got %b want 1", pass); end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        pattern = 8'h00;
        test_reset();
        test_ideal();
        test_delay3();
        test_stuck0();
        test_restart_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
